fproc_meas: RTL and testbench
=============================

# fproc_meas

Function-processor responder for the distributed processor cores. Each core's control FSM raises a one-cycle fproc request with a function id and then stalls in its fproc wait state until `fproc_ready`. This block is the answering end of that handshake. It serves mid-circuit measurement results per core, either the stored latest value or the next fresh one, and holds the returned word stable for the core's ALU.

## Interface
Parameters:
- N_CORES, 4: number of processor cores served.
- N_MEAS, 8: number of measurement channels.
- FUNC_W, 8: function id width. Bit FUNC_W-1 is the mode bit; the low bits are the channel index.
- DATA_W, 32: returned data width, equal to the core ALU width.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- core_req  in  N_CORES  per-core fproc request (the core's `fproc_out_ready`); one-cycle pulse.
- core_func_id  in  N_CORES*FUNC_W  per-core function id; sampled only when the core's req bit is high.
- meas_valid  in  N_MEAS  one-cycle strobe: a new result is available on that channel.
- meas_bit  in  N_MEAS  result value; sampled only when the channel's valid bit is high.
- core_ready  out  N_CORES  per-core `fproc_ready`; one-cycle pulse.
- core_data  out  N_CORES*DATA_W  per-core result, zero-extended from one bit; held until the next response.
- err  out  N_CORES  sticky per core: out-of-range id, or a request arrived while the core was already waiting.

## Operation
- Shared latest-value store `last_bit[N_MEAS]` (reset 0):
  - Updated on every `meas_valid[i]`; `last_bit[i] <= meas_bit[i]`.
- Per-core FSM with states IDLE and WAIT_MEAS (reset IDLE).
- IDLE, `core_req[c]` high, index `idx = func_id[FUNC_W-2:0]`:
  - `idx >= N_MEAS`: respond next cycle with data 0 and set `err[c]`. Stay in IDLE.
  - Mode bit 1 (latest): respond next cycle with `last_bit[idx]`. Stay in IDLE.
    - If `meas_valid[idx]` fires in the same cycle, the response carries the new `meas_bit[idx]`.
  - Mode bit 0 (fresh):
    - If `meas_valid[idx]` fires in the same cycle, respond next cycle with that bit and stay in IDLE.
    - Otherwise store `idx` and go to WAIT_MEAS.
- WAIT_MEAS:
  - On `meas_valid[stored idx]`: respond next cycle with that bit and go to IDLE.
  - A `core_req[c]` here is ignored and sets `err[c]`. The wait continues unchanged.
- One strobe completes every core waiting on that channel in the same cycle. There is no arbitration; cores are independent.
- `err` clears only on reset.

## Timing
- Every response is registered. `core_ready[c]` is high for exactly one cycle, which is the cycle after the triggering event (req or meas_valid).
- `core_data[c]` updates in the same cycle that `core_ready[c]` rises. It then holds until the next response, because the core reads it one cycle after ready.
- Minimum latency is 1 cycle from req to ready. Fresh mode has no maximum latency; a core waits indefinitely.
- Reset values: `core_ready` 0, `core_data` 0, `err` 0, all FSMs IDLE, `last_bit` 0.
- Reset during WAIT_MEAS drops the pending request with no response. A response pulse scheduled for the cycle after reset is suppressed.
- Back-to-back: a request in the cycle after ready is accepted normally.

## Structure
- Package `fproc_pkg`:
  - State enum {IDLE, WAIT_MEAS}.
  - Mode-bit position constant.
  - Localparams `MODE_LATEST` = 1 and `MODE_FRESH` = 0.
- Sub-module `fproc_meas_chan`:
  - One per core, generate-instantiated.
  - Contains the per-core FSM, stored idx, response registers and err.
  - Takes the shared `last_bit`, `meas_valid` and `meas_bit` vectors as inputs.
- Top level holds `last_bit` and the generate loop.

## Test plan
- Latest mode:
  - Stimulus: meas ch2 = 1 at t0; core0 requests id 0x82 at t5.
  - Required: core0 ready at t6 with data 1. No further ready pulses.
- Fresh mode:
  - Stimulus: core1 requests id 0x03 at t0; meas ch3 = 1 at t10.
  - Required: core1 ready at t11 with data 1. Ready stays low for t1–t10.
- Broadcast:
  - Stimulus: cores 0, 2 and 3 wait on ch5 in fresh mode; meas ch5 = 0.
  - Required: all three ready in the same cycle, each with data 0.
- Same-cycle coincidence:
  - Stimulus: core0 fresh request on ch1 and meas ch1 = 1 both at t0.
  - Required: ready at t1 with data 1. The FSM never enters WAIT_MEAS.
- Errors:
  - Stimulus A: id 0x0A with N_MEAS = 8.
  - Required A: ready next cycle, data 0, err set.
  - Stimulus B: a second req while in WAIT_MEAS.
  - Required B: err set, and the original wait completes on the later strobe.
- Reset mid-wait:
  - Stimulus: core2 waits on ch4; reset at t3; meas ch4 at t6.
  - Required: no ready pulse on core2, and `core_data[2]` = 0.

Source files
------------

// File: rtl/fproc_pkg.sv
// Shared definitions for the fproc measurement responder.
//   chan_state_e  : per-core responder FSM state
//   MODE_LATEST   : function-id mode bit value selecting the stored latest result
//   MODE_FRESH    : function-id mode bit value selecting the next fresh result
//   mode_bit_pos  : position of the mode bit inside a function id of given width
package fproc_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_MEAS = 1'b1
    } chan_state_e;

    localparam logic MODE_LATEST = 1'b1;
    localparam logic MODE_FRESH  = 1'b0;

    // The mode bit is always the top bit; the remaining low bits are the channel.
    function automatic int mode_bit_pos(input int func_w);
        return func_w - 1;
    endfunction

endpackage

// File: rtl/fproc_meas_chan.sv
// Per-core fproc responder: decodes one core's function id, answers from the
// shared latest-value store or waits for the next strobe on the requested
// channel, and holds the returned word until the next response.
//
// Handshake: req is a one-cycle pulse from the core; ready is a one-cycle
// pulse exactly one cycle after the triggering event (req or meas strobe),
// and data changes only in the cycle ready is high, then holds.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   req              fproc request pulse from the core
//   func_id          function id, sampled only while req is high
//   last_bit         shared latest-value store
//   meas_valid       per-channel result strobe
//   meas_bit         per-channel result value
//   ready            response pulse to the core
//   data             response word, zero-extended result bit
//   err              sticky error (bad id or request while waiting)
//   state            current FSM state, for observation
module fproc_meas_chan
    import fproc_pkg::*;
#(
    parameter int N_MEAS = 8,
    parameter int FUNC_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [FUNC_W-1:0] func_id,
    input  logic [N_MEAS-1:0] last_bit,
    input  logic [N_MEAS-1:0] meas_valid,
    input  logic [N_MEAS-1:0] meas_bit,
    output logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              err,
    output chan_state_e       state
);

    localparam int MODE_POS = mode_bit_pos(FUNC_W);
    localparam int IDX_W    = FUNC_W - 1;

    chan_state_e       state_next;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  req_idx;
    logic              req_mode;

    // Channel lookups; done by compare loops so an out-of-range id never
    // indexes past the end of the channel vectors.
    logic              req_in_range;
    logic              req_valid_hit;
    logic              req_meas_bit;
    logic              req_last_bit;
    logic              wait_hit;
    logic              wait_bit;

    logic              resp_fire;
    logic              resp_bit;
    logic              err_set;
    logic              idx_load;

    assign req_idx  = func_id[IDX_W-1:0];
    assign req_mode = func_id[MODE_POS];

    always_comb begin
        req_in_range  = 1'b0;
        req_valid_hit = 1'b0;
        req_meas_bit  = 1'b0;
        req_last_bit  = 1'b0;
        wait_hit      = 1'b0;
        wait_bit      = 1'b0;
        for (int i = 0; i < N_MEAS; i++) begin
            if (req_idx == IDX_W'(i)) begin
                req_in_range  = 1'b1;
                req_valid_hit = meas_valid[i];
                req_meas_bit  = meas_bit[i];
                req_last_bit  = last_bit[i];
            end
            if (idx_q == IDX_W'(i)) begin
                wait_hit = meas_valid[i];
                wait_bit = meas_bit[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        resp_fire  = 1'b0;
        resp_bit   = 1'b0;
        err_set    = 1'b0;
        idx_load   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (!req_in_range) begin
                        resp_fire = 1'b1;
                        err_set   = 1'b1;
                    end else if (req_mode == MODE_LATEST) begin
                        // A strobe in the same cycle is newer than the store.
                        resp_fire = 1'b1;
                        resp_bit  = req_valid_hit ? req_meas_bit : req_last_bit;
                    end else if (req_valid_hit) begin
                        resp_fire = 1'b1;
                        resp_bit  = req_meas_bit;
                    end else begin
                        idx_load   = 1'b1;
                        state_next = WAIT_MEAS;
                    end
                end
            end
            WAIT_MEAS: begin
                // A second request is dropped; the original wait carries on.
                err_set = req;
                if (wait_hit) begin
                    resp_fire  = 1'b1;
                    resp_bit   = wait_bit;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q <= '0;
            ready <= 1'b0;
            data  <= '0;
            err   <= 1'b0;
        end else begin
            ready <= resp_fire;
            err   <= err | err_set;
            if (idx_load) begin
                idx_q <= req_idx;
            end
            if (resp_fire) begin
                data <= {{(DATA_W-1){1'b0}}, resp_bit};
            end
        end
    end

endmodule

// File: rtl/fproc_meas.sv
// Measurement function-processor responder for N_CORES processor cores.
// Keeps the latest result of every measurement channel and runs one
// independent responder per core; a single strobe completes every core
// waiting on that channel in the same cycle.
//
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   core_req       per-core fproc request pulse
//   core_func_id   per-core function id (mode bit on top, channel index below)
//   meas_valid     per-channel result strobe
//   meas_bit       per-channel result value
//   core_ready     per-core response pulse
//   core_data      per-core response word, held until the next response
//   err            per-core sticky error
module fproc_meas
    import fproc_pkg::*;
#(
    parameter int N_CORES = 4,
    parameter int N_MEAS  = 8,
    parameter int FUNC_W  = 8,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_CORES-1:0]        core_req,
    input  logic [N_CORES*FUNC_W-1:0] core_func_id,
    input  logic [N_MEAS-1:0]         meas_valid,
    input  logic [N_MEAS-1:0]         meas_bit,
    output logic [N_CORES-1:0]        core_ready,
    output logic [N_CORES*DATA_W-1:0] core_data,
    output logic [N_CORES-1:0]        err
);

    logic [N_MEAS-1:0] last_bit;
    chan_state_e       core_state [N_CORES];

    // Only strobed channels take the new value; the rest hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_bit <= '0;
        end else begin
            last_bit <= (last_bit & ~meas_valid) | (meas_bit & meas_valid);
        end
    end

    for (genvar c = 0; c < N_CORES; c++) begin : g_core
        fproc_meas_chan #(
            .N_MEAS (N_MEAS),
            .FUNC_W (FUNC_W),
            .DATA_W (DATA_W)
        ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .req        (core_req[c]),
            .func_id    (core_func_id[c*FUNC_W +: FUNC_W]),
            .last_bit   (last_bit),
            .meas_valid (meas_valid),
            .meas_bit   (meas_bit),
            .ready      (core_ready[c]),
            .data       (core_data[c*DATA_W +: DATA_W]),
            .err        (err[c]),
            .state      (core_state[c])
        );
    end

endmodule

// File: tb/tb_fproc_meas.sv
// Directed bench for fproc_meas. Drivers push the expected (cycle, data)
// of each response into a per-core queue; a negedge monitor pops and
// compares whenever a core_ready pulse appears.
module tb_fproc_meas;

    localparam int N_CORES = 4;
    localparam int N_MEAS  = 8;
    localparam int FUNC_W  = 8;
    localparam int DATA_W  = 32;

    logic                      clk;
    logic                      reset;
    logic [N_CORES-1:0]        core_req;
    logic [N_CORES*FUNC_W-1:0] core_func_id;
    logic [N_MEAS-1:0]         meas_valid;
    logic [N_MEAS-1:0]         meas_bit;
    logic [N_CORES-1:0]        core_ready;
    logic [N_CORES*DATA_W-1:0] core_data;
    logic [N_CORES-1:0]        err;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    // {expected cycle, expected data}
    logic [63:0] exp_q [N_CORES][$];

    fproc_meas #(
        .N_CORES (N_CORES),
        .N_MEAS  (N_MEAS),
        .FUNC_W  (FUNC_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .core_req     (core_req),
        .core_func_id (core_func_id),
        .meas_valid   (meas_valid),
        .meas_bit     (meas_bit),
        .core_ready   (core_ready),
        .core_data    (core_data),
        .err          (err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
        core_req     = '0;
        core_func_id = '0;
        meas_valid   = '0;
        meas_bit     = '0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_req(input int c, input logic [FUNC_W-1:0] id);
        core_req[c] = 1'b1;
        core_func_id[c*FUNC_W +: FUNC_W] = id;
    endtask

    task automatic drive_meas(input int ch, input logic b);
        meas_valid[ch] = 1'b1;
        meas_bit[ch]   = b;
    endtask

    // Response lands on the edge that samples the current inputs.
    task automatic expect_resp(input int c, input logic d);
        exp_q[c].push_back({32'(cyc + 1), {{(DATA_W-1){1'b0}}, d}});
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            for (int c = 0; c < N_CORES; c++) begin
                if (core_ready[c]) begin
                    tests_run++;
                    if (exp_q[c].size() == 0) begin
                        tests_failed++;
                        $display("FAIL unexpected_ready core=%0d cycle=%0d data=%0h required=no_ready",
                                 c, cyc, core_data[c*DATA_W +: DATA_W]);
                    end else begin
                        logic [63:0] e;
                        e = exp_q[c].pop_front();
                        if (e[63:32] != 32'(cyc) || e[31:0] !== core_data[c*DATA_W +: DATA_W]) begin
                            tests_failed++;
                            $display("FAIL response core=%0d actual cycle=%0d data=%0h required cycle=%0d data=%0h",
                                     c, cyc, core_data[c*DATA_W +: DATA_W], e[63:32], e[31:0]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        reset        = 1'b1;
        core_req     = '0;
        core_func_id = '0;
        meas_valid   = '0;
        meas_bit     = '0;
        ticks(2);
        check("reset_ready", 64'(core_ready), 64'h0);
        check("reset_data", 64'(core_data[63:0]) | 64'(core_data[127:64]), 64'h0);
        check("reset_err", 64'(err), 64'h0);
        reset = 1'b0;
        tick();

        // latest mode: ch2 = 1, then core0 reads 0x82 five cycles later
        drive_meas(2, 1'b1);
        ticks(5);
        drive_req(0, 8'h82);
        expect_resp(0, 1'b1);
        ticks(4);

        // fresh mode: core1 waits on ch3 for ten cycles
        drive_req(1, 8'h03);
        ticks(10);
        drive_meas(3, 1'b1);
        expect_resp(1, 1'b1);
        ticks(3);

        // broadcast: cores 0, 2, 3 wait on ch5, one strobe with 0
        drive_req(0, 8'h05);
        drive_req(2, 8'h05);
        drive_req(3, 8'h05);
        ticks(3);
        drive_meas(5, 1'b0);
        expect_resp(0, 1'b0);
        expect_resp(2, 1'b0);
        expect_resp(3, 1'b0);
        ticks(2);

        // same-cycle fresh request and strobe on ch1; a later ch1 strobe must not answer
        drive_req(0, 8'h01);
        drive_meas(1, 1'b1);
        expect_resp(0, 1'b1);
        ticks(2);
        drive_meas(1, 1'b0);
        ticks(2);

        // latest mode with a coincident strobe uses the new bit (store still 0)
        drive_req(2, 8'h84);
        drive_meas(4, 1'b1);
        expect_resp(2, 1'b1);
        ticks(2);

        // back-to-back latest requests on core0
        drive_req(0, 8'h82);
        expect_resp(0, 1'b1);
        tick();
        drive_req(0, 8'h85);
        expect_resp(0, 1'b0);
        ticks(2);
        check("no_err_yet", 64'(err), 64'h0);

        // error A: out-of-range id on core3 after giving it a nonzero word
        drive_req(3, 8'h82);
        expect_resp(3, 1'b1);
        ticks(2);
        drive_req(3, 8'h0A);
        expect_resp(3, 1'b0);
        ticks(2);
        check("err_bad_id", 64'(err), 64'h8);

        // error B: core1 re-requests while waiting on ch6
        drive_req(1, 8'h06);
        ticks(2);
        drive_req(1, 8'h07);
        tick();
        check("err_rereq", 64'(err), 64'hA);
        drive_meas(7, 1'b1);
        ticks(2);
        drive_meas(6, 1'b1);
        expect_resp(1, 1'b1);
        ticks(2);
        check("err_sticky", 64'(err), 64'hA);

        for (int c = 0; c < N_CORES; c++) begin
            check($sformatf("pending_before_reset_core%0d", c), 64'(exp_q[c].size()), 64'h0);
        end
        check("core2_data_before_reset", 64'(core_data[2*DATA_W +: DATA_W]), 64'h1);

        // reset mid-wait: core2 waits on ch4, reset at t3, strobe at t6
        drive_req(2, 8'h04);
        ticks(3);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ticks(2);
        drive_meas(4, 1'b1);
        ticks(3);
        check("reset_wait_data2", 64'(core_data[2*DATA_W +: DATA_W]), 64'h0);
        check("reset_wait_err", 64'(err), 64'h0);

        // store cleared by reset: latest read of ch2 returns 0
        drive_req(0, 8'h82);
        expect_resp(0, 1'b0);
        ticks(3);

        for (int c = 0; c < N_CORES; c++) begin
            check($sformatf("pending_end_core%0d", c), 64'(exp_q[c].size()), 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
